// File: rtl/ddr_tx_sequencer.sv
// ddr_tx_sequencer
// Frame-level controller for the HDR-DDR tx serializer. Walks one transfer
// through command, write-data, CRC and Restart/Exit phases by presenting a
// mode code to the serializer and advancing on each mode_done pulse. Owns
// the register-file read pointer and the remaining data-word counter.
module ddr_tx_sequencer #(
    parameter int WC_W  = 8,
    parameter int RF_AW = 6
) (
    input  logic             i_sys_clk,
    input  logic             i_sys_rst,
    input  logic             i_start,
    input  logic             i_rnw,
    input  logic [WC_W-1:0]  i_word_count,
    input  logic [RF_AW-1:0] i_regf_base_addr,
    input  logic             i_restart_req,
    input  logic             i_abort,
    input  logic             i_tx_mode_done,
    input  logic             i_rx_done,
    output logic             o_tx_en,
    output logic [3:0]       o_tx_mode,
    output logic             o_crc_en,
    output logic             o_regf_rd_en,
    output logic [RF_AW-1:0] o_regf_rd_addr,
    output logic             o_rx_start,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_aborted
);

    // Serializer mode codes
    localparam logic [3:0] M_CMD  = 4'h0;
    localparam logic [3:0] M_SPRE = 4'h1;
    localparam logic [3:0] M_ONE  = 4'h2;
    localparam logic [3:0] M_ZERO = 4'h3;
    localparam logic [3:0] M_BYTE = 4'h4;
    localparam logic [3:0] M_CPAR = 4'h5;
    localparam logic [3:0] M_DPAR = 4'h6;
    localparam logic [3:0] M_CTOK = 4'h7;
    localparam logic [3:0] M_RST  = 4'h8;
    localparam logic [3:0] M_EXIT = 4'h9;
    localparam logic [3:0] M_ADDR = 4'hA;
    localparam logic [3:0] M_CVAL = 4'hB;

    // D_* states carry one data word; C_* states are the CRC preamble.
    typedef enum logic [4:0] {
        S_IDLE,
        S_SPRE,
        S_CMD,
        S_ADDR,
        S_CPAR,
        S_D_ONE,
        S_D_ZERO,
        S_BYTE_HI,
        S_BYTE_LO,
        S_DPAR,
        S_C_ZERO,
        S_C_ONE,
        S_CTOK,
        S_CVAL,
        S_RST,
        S_EXIT,
        S_WAIT_RX
    } state_t;

    state_t           r_state;
    state_t           w_nxt;
    logic             w_start;
    logic             w_abort;
    logic             w_step;
    logic             w_last_word;

    logic             r_tx_en;
    logic [3:0]       r_tx_mode;
    logic             r_crc_en;
    logic             r_rd_en;
    logic [RF_AW-1:0] r_rd_addr;
    logic             r_rx_start;
    logic             r_busy;
    logic             r_done;
    logic             r_aborted;
    logic             r_rnw;
    logic [WC_W-1:0]  r_words_left;

    // Mode code presented to the serializer while sitting in a state.
    function automatic logic [3:0] f_mode(input state_t s);
        logic [3:0] m;
        m = M_CMD;
        case (s)
            S_SPRE:              m = M_SPRE;
            S_CMD:               m = M_CMD;
            S_ADDR:              m = M_ADDR;
            S_CPAR:              m = M_CPAR;
            S_D_ONE,   S_C_ONE:  m = M_ONE;
            S_D_ZERO,  S_C_ZERO: m = M_ZERO;
            S_BYTE_HI, S_BYTE_LO: m = M_BYTE;
            S_DPAR:              m = M_DPAR;
            S_CTOK:              m = M_CTOK;
            S_CVAL:              m = M_CVAL;
            S_RST:               m = M_RST;
            S_EXIT:              m = M_EXIT;
            default:             m = M_CMD;
        endcase
        return m;
    endfunction

    // Serializer is idle in IDLE and while the rx path owns the bus.
    function automatic logic f_tx_en(input state_t s);
        return (s != S_IDLE) && (s != S_WAIT_RX);
    endfunction

    // CRC covers the command/address words and every data byte.
    function automatic logic f_crc_en(input state_t s);
        return (s == S_CMD) || (s == S_ADDR) || (s == S_BYTE_HI) || (s == S_BYTE_LO);
    endfunction

    function automatic logic f_is_byte(input state_t s);
        return (s == S_BYTE_HI) || (s == S_BYTE_LO);
    endfunction

    // Next-state selection; abort outranks a coincident mode_done.
    always_comb begin
        w_nxt       = r_state;
        w_start     = 1'b0;
        w_abort     = 1'b0;
        w_step      = 1'b0;
        w_last_word = (r_words_left == {{(WC_W-1){1'b0}}, 1'b1});
        if (r_state == S_IDLE) begin
            if (i_start) begin
                w_start = 1'b1;
                w_nxt   = S_SPRE;
            end
        end else if (i_abort && (r_state != S_EXIT)) begin
            w_abort = 1'b1;
            w_nxt   = S_EXIT;
        end else if (r_state == S_WAIT_RX) begin
            if (i_rx_done) w_nxt = S_EXIT;
        end else if (r_tx_en && i_tx_mode_done) begin
            w_step = 1'b1;
            case (r_state)
                S_SPRE:    w_nxt = S_CMD;
                S_CMD:     w_nxt = S_ADDR;
                S_ADDR:    w_nxt = S_CPAR;
                S_CPAR: begin
                    if (r_rnw)
                        w_nxt = S_WAIT_RX;
                    else if (r_words_left == '0)
                        w_nxt = S_C_ZERO;
                    else
                        w_nxt = S_D_ONE;
                end
                S_D_ONE:   w_nxt = S_D_ZERO;
                S_D_ZERO:  w_nxt = S_BYTE_HI;
                S_BYTE_HI: w_nxt = S_BYTE_LO;
                S_BYTE_LO: w_nxt = S_DPAR;
                S_DPAR:    w_nxt = w_last_word ? S_C_ZERO : S_D_ONE;
                S_C_ZERO:  w_nxt = S_C_ONE;
                S_C_ONE:   w_nxt = S_CTOK;
                S_CTOK:    w_nxt = S_CVAL;
                S_CVAL:    w_nxt = i_restart_req ? S_RST : S_EXIT;
                S_RST:     w_nxt = S_IDLE;
                S_EXIT:    w_nxt = S_IDLE;
                default:   w_nxt = S_IDLE;
            endcase
        end
    end

    // State register plus registered outputs derived from the next state,
    // so the new mode is on the pins the cycle the state is entered.
    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
            r_state      <= S_IDLE;
            r_tx_en      <= 1'b0;
            r_tx_mode    <= 4'h0;
            r_crc_en     <= 1'b0;
            r_rd_en      <= 1'b0;
            r_rd_addr    <= '0;
            r_rx_start   <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_aborted    <= 1'b0;
            r_rnw        <= 1'b0;
            r_words_left <= '0;
        end else begin
            r_state    <= w_nxt;
            r_tx_en    <= f_tx_en(w_nxt);
            r_tx_mode  <= f_mode(w_nxt);
            r_crc_en   <= f_crc_en(w_nxt);
            r_busy     <= (w_nxt != S_IDLE);
            r_rd_en    <= f_is_byte(w_nxt) && (w_nxt != r_state);
            r_rx_start <= (w_nxt == S_WAIT_RX) && (r_state != S_WAIT_RX);
            r_done     <= (w_nxt == S_IDLE) && (r_state != S_IDLE);
            if (w_start) begin
                r_rnw        <= i_rnw;
                r_words_left <= i_word_count;
                r_rd_addr    <= i_regf_base_addr;
                r_aborted    <= 1'b0;
            end else begin
                if (w_abort) r_aborted <= 1'b1;
                // Pointer moves past a byte once it has been shifted out.
                if (w_step && f_is_byte(r_state))
                    r_rd_addr <= r_rd_addr + {{(RF_AW-1){1'b0}}, 1'b1};
                // One word fewer remaining after its parity is sent.
                if (w_step && (r_state == S_DPAR))
                    r_words_left <= r_words_left - {{(WC_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign o_tx_en        = r_tx_en;
    assign o_tx_mode      = r_tx_mode;
    assign o_crc_en       = r_crc_en;
    assign o_regf_rd_en   = r_rd_en;
    assign o_regf_rd_addr = r_rd_addr;
    assign o_rx_start     = r_rx_start;
    assign o_busy         = r_busy;
    assign o_done         = r_done;
    assign o_aborted      = r_aborted;

endmodule

// File: tb/tb_ddr_tx_sequencer.sv
// Directed bench for ddr_tx_sequencer: plays the serializer by pulsing
// mode_done for each expected mode and checks traces, strobes and pulses.
module tb_ddr_tx_sequencer;
    localparam int WC_W  = 8;
    localparam int RF_AW = 6;

    logic             clk = 1'b0;
    logic             rst;
    logic             i_start = 1'b0;
    logic             i_rnw = 1'b0;
    logic [WC_W-1:0]  i_word_count = '0;
    logic [RF_AW-1:0] i_base = '0;
    logic             i_restart_req = 1'b0;
    logic             i_abort = 1'b0;
    logic             i_tx_mode_done = 1'b0;
    logic             i_rx_done = 1'b0;
    logic             o_tx_en;
    logic [3:0]       o_tx_mode;
    logic             o_crc_en;
    logic             o_regf_rd_en;
    logic [RF_AW-1:0] o_regf_rd_addr;
    logic             o_rx_start;
    logic             o_busy;
    logic             o_done;
    logic             o_aborted;

    int errors = 0;
    int checks = 0;

    logic [RF_AW-1:0] rd_log [0:63];
    int nrd = 0;
    int ndone = 0;
    int nrxs = 0;
    int rd0;
    int dn0;
    logic [3:0] q [$];

    always #5 clk = ~clk;

    ddr_tx_sequencer #(.WC_W(WC_W), .RF_AW(RF_AW)) dut (
        .i_sys_clk(clk), .i_sys_rst(rst), .i_start(i_start), .i_rnw(i_rnw),
        .i_word_count(i_word_count), .i_regf_base_addr(i_base),
        .i_restart_req(i_restart_req), .i_abort(i_abort),
        .i_tx_mode_done(i_tx_mode_done), .i_rx_done(i_rx_done),
        .o_tx_en(o_tx_en), .o_tx_mode(o_tx_mode), .o_crc_en(o_crc_en),
        .o_regf_rd_en(o_regf_rd_en), .o_regf_rd_addr(o_regf_rd_addr),
        .o_rx_start(o_rx_start), .o_busy(o_busy), .o_done(o_done),
        .o_aborted(o_aborted)
    );

    // Log strobes/pulses as seen during each cycle (sampled before update).
    always @(posedge clk) begin
        if (o_regf_rd_en && nrd < 64) begin
            rd_log[nrd] = o_regf_rd_addr;
            nrd = nrd + 1;
        end
        if (o_done) ndone = ndone + 1;
        if (o_rx_start) nrxs = nrxs + 1;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait for the serializer enable, check the mode is presented and held,
    // then acknowledge it with a one-cycle mode_done.
    task automatic serve(input logic [3:0] m, input logic crc, input string tag);
        int n;
        n = 0;
        while (!o_tx_en && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(o_tx_en, 1, {tag, " tx_en"});
        chk(o_tx_mode, m, {tag, " mode"});
        chk(o_crc_en, crc, {tag, " crc_en"});
        @(negedge clk);
        chk(o_tx_mode, m, {tag, " mode hold"});
        i_tx_mode_done = 1'b1;
        @(negedge clk);
        i_tx_mode_done = 1'b0;
    endtask

    // Serve the queued mode trace; CMD/ADDR are positions 1/2 of every trace.
    task automatic run_trace(input string tag);
        for (int i = 0; i < q.size(); i++)
            serve(q[i], (i == 1) || (i == 2) || (q[i] == 4'h4), $sformatf("%s[%0d]", tag, i));
    endtask

    task automatic start_xfer(input logic rnw, input int cnt, input int base, input logic rs);
        i_rnw         = rnw;
        i_word_count  = WC_W'(cnt);
        i_base        = RF_AW'(base);
        i_restart_req = rs;
        i_start       = 1'b1;
        @(negedge clk);
        i_start       = 1'b0;
    endtask

    task automatic chk_end(input string tag);
        chk(o_done, 1, {tag, " done pulse"});
        chk(o_busy, 0, {tag, " busy low"});
        chk(o_tx_en, 0, {tag, " tx_en low"});
        @(negedge clk);
        chk(o_done, 0, {tag, " done 1-cycle"});
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk(o_tx_en, 0, "rst tx_en");
        chk(o_tx_mode, 0, "rst mode");
        chk(o_busy, 0, "rst busy");
        chk(o_regf_rd_addr, 0, "rst addr");
        chk({o_crc_en, o_regf_rd_en, o_rx_start, o_done, o_aborted}, 0, "rst misc");
        rst = 1'b0;
        @(negedge clk);

        // Write, one word from address 5, exit
        rd0 = nrd; dn0 = ndone;
        start_xfer(1'b0, 1, 5, 1'b0);
        chk(o_busy, 1, "wr1 busy");
        q = '{4'h1, 4'h0, 4'hA, 4'h5, 4'h2, 4'h3, 4'h4, 4'h4, 4'h6, 4'h3, 4'h2, 4'h7, 4'hB, 4'h9};
        run_trace("wr1");
        chk_end("wr1");
        chk(nrd - rd0, 2, "wr1 rd count");
        chk(rd_log[rd0], 5, "wr1 rd addr0");
        chk(rd_log[rd0+1], 6, "wr1 rd addr1");
        chk(ndone - dn0, 1, "wr1 done count");

        // Write, zero words; a second start while busy must not relatch
        rd0 = nrd;
        start_xfer(1'b0, 0, 9, 1'b0);
        i_rnw = 1'b1; i_word_count = 8'd5; i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0; i_rnw = 1'b0;
        q = '{4'h1, 4'h0, 4'hA, 4'h5, 4'h3, 4'h2, 4'h7, 4'hB, 4'h9};
        run_trace("wr0");
        chk_end("wr0");
        chk(nrd - rd0, 0, "wr0 no rd");

        // Read
        dn0 = ndone;
        start_xfer(1'b1, 0, 0, 1'b0);
        q = '{4'h1, 4'h0, 4'hA, 4'h5};
        run_trace("rd");
        chk(o_rx_start, 1, "rd rx_start");
        chk(o_tx_en, 0, "rd tx_en off");
        chk(o_busy, 1, "rd busy");
        i_tx_mode_done = 1'b1;
        @(negedge clk);
        i_tx_mode_done = 1'b0;
        chk(o_rx_start, 0, "rd rx_start 1-cycle");
        repeat (3) @(negedge clk);
        chk(o_tx_en, 0, "rd stray done ignored");
        chk(o_busy, 1, "rd waiting");
        i_rx_done = 1'b1;
        @(negedge clk);
        i_rx_done = 1'b0;
        i_rnw = 1'b0;
        serve(4'h9, 1'b0, "rd exit");
        chk_end("rd");
        chk(nrxs, 1, "rd rx_start count");
        chk(ndone - dn0, 1, "rd done count");

        // Write, three words from 63 (wraps), restart
        rd0 = nrd;
        start_xfer(1'b0, 3, 63, 1'b1);
        q = '{4'h1, 4'h0, 4'hA, 4'h5};
        repeat (3) begin
            q.push_back(4'h2); q.push_back(4'h3); q.push_back(4'h4);
            q.push_back(4'h4); q.push_back(4'h6);
        end
        q.push_back(4'h3); q.push_back(4'h2); q.push_back(4'h7);
        q.push_back(4'hB); q.push_back(4'h8);
        run_trace("wr3");
        chk_end("wr3");
        i_restart_req = 1'b0;
        chk(nrd - rd0, 6, "wr3 rd count");
        chk(rd_log[rd0], 63, "wr3 rd addr0");
        chk(rd_log[rd0+1], 0, "wr3 rd wrap");
        chk(rd_log[rd0+5], 4, "wr3 rd addr5");

        // Abort during second BYTE, coincident with mode_done
        rd0 = nrd;
        start_xfer(1'b0, 2, 10, 1'b0);
        q = '{4'h1, 4'h0, 4'hA, 4'h5, 4'h2, 4'h3, 4'h4};
        run_trace("ab");
        chk(o_tx_mode, 4'h4, "ab byte_lo");
        i_abort = 1'b1; i_tx_mode_done = 1'b1;
        @(negedge clk);
        i_abort = 1'b0; i_tx_mode_done = 1'b0;
        chk(o_tx_mode, 4'h9, "ab exit mode");
        chk(o_aborted, 1, "ab aborted");
        chk(o_done, 0, "ab no early done");
        serve(4'h9, 1'b0, "ab exit");
        chk_end("ab");
        chk(o_aborted, 1, "ab sticky");
        chk(nrd - rd0, 2, "ab rd count");
        chk(rd_log[rd0+1], 11, "ab rd addr1");

        // Next accepted start clears the sticky abort
        start_xfer(1'b0, 0, 0, 1'b0);
        chk(o_aborted, 0, "ab cleared");
        q = '{4'h1, 4'h0, 4'hA, 4'h5, 4'h3, 4'h2, 4'h7, 4'hB, 4'h9};
        run_trace("ab2");
        chk_end("ab2");

        // Reset mid-ADDR
        start_xfer(1'b0, 1, 3, 1'b0);
        q = '{4'h1, 4'h0};
        run_trace("mr");
        chk(o_tx_mode, 4'hA, "mr in addr");
        rst = 1'b1;
        #1;
        chk(o_tx_en, 0, "mr tx_en");
        chk(o_tx_mode, 0, "mr mode");
        chk(o_busy, 0, "mr busy");
        chk(o_regf_rd_addr, 0, "mr addr");
        chk(o_crc_en, 0, "mr crc");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Start after reset is accepted
        rd0 = nrd;
        start_xfer(1'b0, 1, 0, 1'b1);
        q = '{4'h1, 4'h0, 4'hA, 4'h5, 4'h2, 4'h3, 4'h4, 4'h4, 4'h6, 4'h3, 4'h2, 4'h7, 4'hB, 4'h8};
        run_trace("pr");
        chk_end("pr");
        chk(rd_log[rd0+1], 1, "pr rd addr1");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
